// File: rtl/hazard_pkg.sv
// Shared ISA field constants and stall-reason encoding for the hazard scoreboard.
package hazard_pkg;

   localparam logic [4:0] OP_RTYPE = 5'b00000;
   localparam logic [4:0] OP_J     = 5'b00001;
   localparam logic [4:0] OP_BNE   = 5'b00010;
   localparam logic [4:0] OP_JAL   = 5'b00011;
   localparam logic [4:0] OP_JR    = 5'b00100;
   localparam logic [4:0] OP_ADDI  = 5'b00101;
   localparam logic [4:0] OP_BLT   = 5'b00110;
   localparam logic [4:0] OP_SW    = 5'b00111;
   localparam logic [4:0] OP_LW    = 5'b01000;
   localparam logic [4:0] OP_SETX  = 5'b10101;
   localparam logic [4:0] OP_BEX   = 5'b10110;

   localparam logic [4:0] ALU_ADD  = 5'b00000;
   localparam logic [4:0] ALU_SUB  = 5'b00001;
   localparam logic [4:0] ALU_MUL  = 5'b00110;
   localparam logic [4:0] ALU_DIV  = 5'b00111;

   localparam int REG_RSTATUS = 30;
   localparam int REG_RA      = 31;

   typedef enum logic [1:0] {
      SR_NONE = 2'b00,
      SR_RAW  = 2'b01,
      SR_WAW  = 2'b10,
      SR_BUSY = 2'b11
   } stall_reason_e;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/hazard_decode.sv
// Combinational decode of the F/D instruction into source/destination register
// indices, mult/div flag and producer latency.
module hazard_decode
   import hazard_pkg::*;
#(
   parameter int REG_W    = 5,
   parameter int LOAD_LAT = 1,
   parameter int MD_LAT   = 32,
   parameter int CNT_W    = 6
) (
   input  logic [31:0]      i_ir,
   output logic [REG_W-1:0] o_src1,
   output logic             o_src1_v,
   output logic [REG_W-1:0] o_src2,
   output logic             o_src2_v,
   output logic [REG_W-1:0] o_src3,
   output logic             o_src3_v,
   output logic [REG_W-1:0] o_dst1,
   output logic             o_dst1_v,
   output logic [REG_W-1:0] o_dst2,
   output logic             o_dst2_v,
   output logic             o_is_md,
   output logic [CNT_W-1:0] o_lat
);

   logic [4:0] w_op, w_rd, w_rs, w_rt, w_alu;
   logic       w_unused_bits;

   assign w_op          = i_ir[31:27];
   assign w_rd          = i_ir[26:22];
   assign w_rs          = i_ir[21:17];
   assign w_rt          = i_ir[16:12];
   assign w_alu         = i_ir[6:2];
   assign w_unused_bits = ^{i_ir[11:7], i_ir[1:0]};

   always_comb begin
      o_is_md  = (w_op == OP_RTYPE) && (w_alu == ALU_MUL || w_alu == ALU_DIV);

      o_src1   = REG_W'(w_rs);
      o_src1_v = !(w_op inside {OP_J, OP_JAL, OP_SETX, OP_BEX});
      o_src2   = REG_W'(w_rt);
      o_src2_v = (w_op == OP_RTYPE);
      // bex has no rd operand, so its implicit r30 read rides in the third slot
      o_src3   = (w_op == OP_BEX) ? REG_W'(REG_RSTATUS) : REG_W'(w_rd);
      o_src3_v = w_op inside {OP_SW, OP_BNE, OP_JR, OP_BLT, OP_BEX};

      o_dst1   = REG_W'(w_rd);
      o_dst1_v = 1'b0;
      case (w_op)
         OP_RTYPE, OP_ADDI, OP_LW: o_dst1_v = 1'b1;
         OP_JAL:  begin o_dst1 = REG_W'(REG_RA);      o_dst1_v = 1'b1; end
         OP_SETX: begin o_dst1 = REG_W'(REG_RSTATUS); o_dst1_v = 1'b1; end
         default: ;
      endcase

      o_dst2   = REG_W'(REG_RSTATUS);
      o_dst2_v = (w_op == OP_RTYPE) && (w_alu inside {ALU_ADD, ALU_SUB, ALU_MUL, ALU_DIV});

      o_lat = '0;
      if (w_op == OP_LW) o_lat = CNT_W'(LOAD_LAT);
      else if (o_is_md)  o_lat = CNT_W'(MD_LAT);
   end

endmodule

// File: rtl/hazard_scoreboard.sv
// Per-register countdown scoreboard raising F/D stalls on RAW, WAW and mult/div busy.
// Define HAZARD_PERF_CNT_EN to add saturating per-reason stall-cycle counters.
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int NUM_REGS = 32,
   parameter int REG_W    = 5,
   parameter int LOAD_LAT = 1,
   parameter int MD_LAT   = 32,
   parameter int CNT_W    = $clog2(max_int(LOAD_LAT, MD_LAT) + 1)
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic [31:0]         ir_fd,
   input  logic                fd_valid,
   input  logic                flush,
   output logic                stall,
   output logic [1:0]          stall_reason,
   output logic                md_busy,
   output logic [NUM_REGS-1:0] pending_mask
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [31:0]         raw_stall_cycles,
   output logic [31:0]         waw_stall_cycles,
   output logic [31:0]         md_stall_cycles
`endif
);

   logic [REG_W-1:0] w_src1, w_src2, w_src3, w_dst1, w_dst2;
   logic             w_src1_v, w_src2_v, w_src3_v, w_dst1_v, w_dst2_v;
   logic             w_is_md;
   logic [CNT_W-1:0] w_lat;

   hazard_decode #(
      .REG_W    (REG_W),
      .LOAD_LAT (LOAD_LAT),
      .MD_LAT   (MD_LAT),
      .CNT_W    (CNT_W)
   ) u_dec (
      .i_ir     (ir_fd),
      .o_src1   (w_src1), .o_src1_v (w_src1_v),
      .o_src2   (w_src2), .o_src2_v (w_src2_v),
      .o_src3   (w_src3), .o_src3_v (w_src3_v),
      .o_dst1   (w_dst1), .o_dst1_v (w_dst1_v),
      .o_dst2   (w_dst2), .o_dst2_v (w_dst2_v),
      .o_is_md  (w_is_md),
      .o_lat    (w_lat)
   );

   logic [CNT_W-1:0]    r_cnt [NUM_REGS];
   logic [CNT_W-1:0]    r_md_cnt;
   logic [NUM_REGS-1:0] w_pend;
   logic                w_d1_v, w_d2_v;
   logic                w_raw, w_waw, w_busy, w_act, w_issue;
   stall_reason_e       w_reason;

   always_comb begin
      w_pend = '0;
      for (int r = 1; r < NUM_REGS; r++) w_pend[r] = (r_cnt[r] != '0);
   end

   assign w_d1_v = w_dst1_v && (w_dst1 != '0);
   assign w_d2_v = w_dst2_v && (w_dst2 != '0);

   assign w_raw = (w_src1_v && w_src1 != '0 && w_pend[w_src1])
                | (w_src2_v && w_src2 != '0 && w_pend[w_src2])
                | (w_src3_v && w_src3 != '0 && w_pend[w_src3]);
   // A mul/div's r30 write always lands after any older r30 write, so its
   // only real conflict with an in-flight mul/div is the structural one.
   assign w_waw = (w_d1_v && w_pend[w_dst1])
                | (w_d2_v && !w_is_md && w_pend[w_dst2]);
   assign w_busy  = w_is_md && md_busy;
   assign w_act   = fd_valid && !flush;
   assign stall   = w_act && (w_raw || w_waw || w_busy);
   assign w_issue = w_act && !stall;

   always_comb begin
      w_reason = SR_NONE;
      if (w_act) begin
         if (w_raw)       w_reason = SR_RAW;
         else if (w_waw)  w_reason = SR_WAW;
         else if (w_busy) w_reason = SR_BUSY;
      end
   end

   assign stall_reason = w_reason;
   assign pending_mask = w_pend;
   assign md_busy      = (r_md_cnt != '0);

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         for (int r = 0; r < NUM_REGS; r++) r_cnt[r] <= '0;
         r_md_cnt <= '0;
      end else begin
         for (int r = 1; r < NUM_REGS; r++) begin
            if (w_issue && w_lat != '0 &&
                ((w_d1_v && w_dst1 == REG_W'(r)) || (w_d2_v && w_dst2 == REG_W'(r))))
               r_cnt[r] <= w_lat;
            else if (r_cnt[r] != '0)
               r_cnt[r] <= r_cnt[r] - CNT_W'(1);
         end
         r_cnt[0] <= '0;
         if (w_issue && w_is_md)  r_md_cnt <= CNT_W'(MD_LAT);
         else if (r_md_cnt != '0) r_md_cnt <= r_md_cnt - CNT_W'(1);
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] r_raw_cyc, r_waw_cyc, r_md_cyc;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_raw_cyc <= '0;
         r_waw_cyc <= '0;
         r_md_cyc  <= '0;
      end else begin
         if (stall && w_reason == SR_RAW  && r_raw_cyc != '1) r_raw_cyc <= r_raw_cyc + 32'd1;
         if (stall && w_reason == SR_WAW  && r_waw_cyc != '1) r_waw_cyc <= r_waw_cyc + 32'd1;
         if (stall && w_reason == SR_BUSY && r_md_cyc  != '1) r_md_cyc  <= r_md_cyc  + 32'd1;
      end
   end

   assign raw_stall_cycles = r_raw_cyc;
   assign waw_stall_cycles = r_waw_cyc;
   assign md_stall_cycles  = r_md_cyc;
`endif

endmodule
